timer_dev: RTL

- Memory-mapped countdown timer; a word-addressed responder on the M-stage data bus behind the bridge.
- Occupies one 12-byte window, 0x7f00–0x7f0b or 0x7f10–0x7f1b; the bridge decodes the base and presents `Addr[3:2]`.
- The CPU reaches it only with `sw`/`lw`. Sub-word accesses are trapped upstream as AdEL/AdES, so they never reach this block.
- Raises an interrupt request toward CP0 when the count expires.

---
 rtl/timer_dev.sv | 135 +++++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer on the M-stage data bus.
//
// Register window (word select from the bridge's Addr[3:2]):
//   00 CTRL   : bit0 Enable, bits[2:1] Mode, bit3 IM (interrupt mask)
//   01 PRESET : reload value
//   10 COUNT  : current count (read-only)
//   11 unused : reads as zero, writes ignored
//
// Ports:
//   clk   - single clock, rising-edge state updates
//   reset - asynchronous active-low reset
//   Addr  - word select
//   WE    - write enable (already qualified by the bridge)
//   DIN   - write data
//   DOUT  - combinational read data selected by Addr
//   IRQ   - interrupt request toward CP0 (irq flag gated by IM)
module timer_dev #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Addr,
  input  logic             WE,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_t           state_r;
  logic [3:0]       ctrl_r;
  logic [WIDTH-1:0] preset_r;
  logic [WIDTH-1:0] count_r;
  logic             irq_flag_r;

  logic             enable_s;
  logic [1:0]       mode_s;
  logic             im_s;

  assign enable_s = ctrl_r[0];
  assign mode_s   = ctrl_r[2:1];
  assign im_s     = ctrl_r[3];

  // Timer FSM plus bus writes; the bus write is applied last so a CTRL
  // write overrides whatever the FSM did to ctrl/irq_flag on the same edge,
  // while the FSM's next state is still decided from the pre-write ctrl.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ctrl_r     <= 4'd0;
      preset_r   <= '0;
      count_r    <= '0;
      irq_flag_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable_s) begin
            state_r    <= ST_LOAD;
            irq_flag_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          count_r <= preset_r;
          state_r <= ST_CNT;
        end
        ST_CNT: begin
          if (!enable_s) begin
            // Disabled mid-count: count is frozen where it stands.
            state_r <= ST_IDLE;
          end else if (count_r == '0) begin
            state_r    <= ST_INT;
            irq_flag_r <= 1'b1;
          end else begin
            count_r <= count_r - WIDTH'(1);
          end
        end
        ST_INT: begin
          if (mode_s == MODE_RELOAD) begin
            irq_flag_r <= 1'b0;
            state_r    <= ST_LOAD;
          end else begin
            // One-shot (and the two undefined modes): stop and keep the flag.
            ctrl_r[0] <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (WE) begin
        case (Addr)
          ADDR_CTRL: begin
            ctrl_r     <= DIN[3:0];
            irq_flag_r <= 1'b0;
          end
          ADDR_PRESET: begin
            preset_r <= DIN;
          end
          default: begin
            // COUNT is read-only and the fourth word is unused.
          end
        endcase
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    DOUT = '0;
    case (Addr)
      ADDR_CTRL:   DOUT = {{(WIDTH-4){1'b0}}, ctrl_r};
      ADDR_PRESET: DOUT = preset_r;
      ADDR_COUNT:  DOUT = count_r;
      default:     DOUT = '0;
    endcase
  end

  assign IRQ = irq_flag_r & im_s;

endmodule
